// File: rtl/pong_game_ctrl_pkg.sv
// rtl/pong_game_ctrl_pkg.sv - game modes, screen/paddle geometry and paddle stepping helper
package pong_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int PADDLE_H    = 64;
  localparam int PADDLE_W    = 8;
  localparam int PADDLE_X1   = 16;
  localparam int PADDLE_X2   = 616;
  localparam int BALL_SIZE   = 8;
  localparam int PADDLE_STEP = 4;
  localparam int BALL_STEP   = 2;
  localparam int WIN_SCORE   = 9;
  localparam int SERVE_DELAY = 60;

  localparam logic [10:0] BALL_CX   = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] BALL_CY   = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] PADDLE_CY = 11'((V_ACTIVE - PADDLE_H) / 2);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_SERVE = 2'd1,
    MODE_PLAY  = 2'd2,
    MODE_OVER  = 2'd3
  } mode_t;

  // Signed intermediate so moving up from near 0 clamps instead of wrapping.
  function automatic logic [10:0] paddle_next(input logic [10:0] y, input logic up,
                                              input logic down);
    logic signed [11:0] t;
    t = $signed({1'b0, y});
    if (up && !down) t = t - 12'(PADDLE_STEP);
    else if (down && !up) t = t + 12'(PADDLE_STEP);
    if (t < 12'sd0) t = 12'sd0;
    else if (t > 12'(V_ACTIVE - PADDLE_H)) t = 12'(V_ACTIVE - PADDLE_H);
    return 11'(t);
  endfunction

endpackage

// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - combinational one-frame ball step with wall, paddle and miss resolution
module pong_ball_engine
  import pong_pkg::*;
(
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic        dx,
  input  logic        dy,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] next_x,
  output logic [10:0] next_y,
  output logic        next_dx,
  output logic        next_dy,
  output logic        miss_left,
  output logic        miss_right
);

  localparam logic signed [11:0] STEP   = 12'(BALL_STEP);
  localparam logic signed [11:0] SIZE   = 12'(BALL_SIZE);
  localparam logic signed [11:0] L_FACE = 12'(PADDLE_X1 + PADDLE_W);
  localparam logic signed [11:0] L_BACK = 12'(PADDLE_X1);
  localparam logic signed [11:0] R_FACE = 12'(PADDLE_X2);
  localparam logic signed [11:0] R_BACK = 12'(PADDLE_X2 + PADDLE_W);
  localparam logic signed [11:0] X_MAX  = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic [11:0]        PH     = 12'(PADDLE_H);
  localparam logic [11:0]        BS     = 12'(BALL_SIZE);

  logic signed [11:0] sx, sy, nx, ny;
  logic [11:0] by;
  logic ov_left, ov_right, hit_left, hit_right;

  always_comb begin
    by        = {1'b0, ball_y};
    sx        = $signed({1'b0, ball_x}) + (dx ? STEP : -STEP);
    sy        = $signed({1'b0, ball_y}) + (dy ? STEP : -STEP);
    ov_left   = (by + BS > {1'b0, p1_y}) && (by < {1'b0, p1_y} + PH);
    ov_right  = (by + BS > {1'b0, p2_y}) && (by < {1'b0, p2_y} + PH);
    hit_left  = !dx && (sx <= L_FACE) && (sx + SIZE > L_BACK) && ov_left;
    hit_right = dx && (sx + SIZE >= R_FACE) && (sx < R_BACK) && ov_right;

    nx         = sx;
    ny         = sy;
    next_dx    = dx;
    next_dy    = dy;
    miss_left  = 1'b0;
    miss_right = 1'b0;

    if (sy <= 12'sd0) begin
      ny      = 12'sd0;
      next_dy = 1'b1;
    end else if (sy >= Y_MAX) begin
      ny      = Y_MAX;
      next_dy = 1'b0;
    end

    // Hits take priority over misses; wall handling above is independent.
    if (hit_left) begin
      nx      = L_FACE;
      next_dx = 1'b1;
    end else if (hit_right) begin
      nx      = R_FACE - SIZE;
      next_dx = 1'b0;
    end else if (sx <= 12'sd0) begin
      miss_left = 1'b1;
    end else if (sx >= X_MAX) begin
      miss_right = 1'b1;
    end

    // Re-serve toward the player who conceded.
    if (miss_left || miss_right) begin
      nx      = $signed({1'b0, BALL_CX});
      ny      = $signed({1'b0, BALL_CY});
      next_dx = miss_right;
    end

    next_x = 11'(nx);
    next_y = 11'(ny);
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-rate pong controller: mode FSM, paddles, ball registers and scores
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        start,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  output logic [1:0]  mode,
  output logic [5:0]  p1_score,
  output logic [5:0]  p2_score,
  output logic [10:0] p1_y,
  output logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y
);

  mode_t       state, state_nx;
  logic        vsync_q, tick;
  logic [5:0]  serve_cnt, serve_cnt_nx, p1_score_nx, p2_score_nx;
  logic [10:0] p1_y_nx, p2_y_nx, ball_x_nx, ball_y_nx;
  logic        dx, dy, dx_nx, dy_nx;
  logic [10:0] eng_x, eng_y;
  logic        eng_dx, eng_dy, miss_left, miss_right;

  assign tick = vsync & ~vsync_q;
  assign mode = state;

  pong_ball_engine u_ball (
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .dx        (dx),
    .dy        (dy),
    .p1_y      (p1_y),
    .p2_y      (p2_y),
    .next_x    (eng_x),
    .next_y    (eng_y),
    .next_dx   (eng_dx),
    .next_dy   (eng_dy),
    .miss_left (miss_left),
    .miss_right(miss_right)
  );

  always_comb begin
    state_nx     = state;
    serve_cnt_nx = serve_cnt;
    p1_score_nx  = p1_score;
    p2_score_nx  = p2_score;
    p1_y_nx      = p1_y;
    p2_y_nx      = p2_y;
    ball_x_nx    = ball_x;
    ball_y_nx    = ball_y;
    dx_nx        = dx;
    dy_nx        = dy;
    if (tick) begin
      case (state)
        MODE_IDLE, MODE_OVER: begin
          if (start) begin
            p1_score_nx  = '0;
            p2_score_nx  = '0;
            ball_x_nx    = BALL_CX;
            ball_y_nx    = BALL_CY;
            dx_nx        = 1'b1;
            serve_cnt_nx = '0;
            state_nx     = MODE_SERVE;
          end
        end
        MODE_SERVE: begin
          p1_y_nx = paddle_next(p1_y, p1_up, p1_down);
          p2_y_nx = paddle_next(p2_y, p2_up, p2_down);
          if (serve_cnt == 6'(SERVE_DELAY - 1)) begin
            serve_cnt_nx = '0;
            state_nx     = MODE_PLAY;
          end else begin
            serve_cnt_nx = serve_cnt + 6'd1;
          end
        end
        MODE_PLAY: begin
          p1_y_nx   = paddle_next(p1_y, p1_up, p1_down);
          p2_y_nx   = paddle_next(p2_y, p2_up, p2_down);
          ball_x_nx = eng_x;
          ball_y_nx = eng_y;
          dx_nx     = eng_dx;
          dy_nx     = eng_dy;
          if (miss_left) begin
            p2_score_nx = p2_score + 6'd1;
            state_nx    = (p2_score_nx == 6'(WIN_SCORE)) ? MODE_OVER : MODE_SERVE;
          end else if (miss_right) begin
            p1_score_nx = p1_score + 6'd1;
            state_nx    = (p1_score_nx == 6'(WIN_SCORE)) ? MODE_OVER : MODE_SERVE;
          end
        end
        default: state_nx = MODE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MODE_IDLE;
      vsync_q   <= 1'b0;
      serve_cnt <= '0;
      p1_score  <= '0;
      p2_score  <= '0;
      p1_y      <= PADDLE_CY;
      p2_y      <= PADDLE_CY;
      ball_x    <= BALL_CX;
      ball_y    <= BALL_CY;
      dx        <= 1'b1;
      dy        <= 1'b1;
    end else begin
      state     <= state_nx;
      vsync_q   <= vsync;
      serve_cnt <= serve_cnt_nx;
      p1_score  <= p1_score_nx;
      p2_score  <= p2_score_nx;
      p1_y      <= p1_y_nx;
      p2_y      <= p2_y_nx;
      ball_x    <= ball_x_nx;
      ball_y    <= ball_y_nx;
      dx        <= dx_nx;
      dy        <= dy_nx;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - ball engine vector table plus frame-level game checks against a reference model
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1, vsync = 1'b0, start = 1'b0;
  logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [1:0]  mode;
  logic [5:0]  p1_score, p2_score;
  logic [10:0] p1_y, p2_y, ball_x, ball_y;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .mode(mode), .p1_score(p1_score), .p2_score(p2_score),
    .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y)
  );

  logic [10:0] e_bx = 0, e_by = 0, e_p1 = 0, e_p2 = 0, e_nx, e_ny;
  logic e_dx = 0, e_dy = 0, e_ndx, e_ndy, e_ml, e_mr;

  pong_ball_engine eng (
    .ball_x(e_bx), .ball_y(e_by), .dx(e_dx), .dy(e_dy), .p1_y(e_p1), .p2_y(e_p2),
    .next_x(e_nx), .next_y(e_ny), .next_dx(e_ndx), .next_dy(e_ndy),
    .miss_left(e_ml), .miss_right(e_mr)
  );

  typedef struct {
    int bx, by, dx, dy, p1, p2;
    int ex, ey, edx, edy, eml, emr;
  } vec_t;
  vec_t vecs[$];

  int n_cmp = 0, n_fail = 0;

  // Reference game state: directions are +1/-1, mode uses the output numbering.
  int m_mode, m_s1, m_s2, m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_cnt;

  task automatic add_vec(input int bx, by, dx, dy, p1, p2, ex, ey, edx, edy, eml, emr);
    vec_t v;
    v.bx = bx; v.by = by; v.dx = dx; v.dy = dy; v.p1 = p1; v.p2 = p2;
    v.ex = ex; v.ey = ey; v.edx = edx; v.edy = edy; v.eml = eml; v.emr = emr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name);
    n_cmp++;
    if (mode !== 2'(m_mode) || p1_score !== 6'(m_s1) || p2_score !== 6'(m_s2) ||
        p1_y !== 11'(m_p1) || p2_y !== 11'(m_p2) || ball_x !== 11'(m_bx) || ball_y !== 11'(m_by)) begin
      n_fail++;
      $display("FAIL %s: got mode=%0d score=%0d/%0d pad=%0d/%0d ball=%0d,%0d expected mode=%0d score=%0d/%0d pad=%0d/%0d ball=%0d,%0d",
               name, mode, p1_score, p2_score, p1_y, p2_y, ball_x, ball_y,
               m_mode, m_s1, m_s2, m_p1, m_p2, m_bx, m_by);
    end
  endtask

  function automatic int pad(input int y, input bit u, input bit d);
    if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
    if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function automatic bit y_overlap(input int by, input int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_s1 = 0; m_s2 = 0; m_p1 = 208; m_p2 = 208;
    m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_cnt = 0;
  endtask

  task automatic model_tick(input bit st, input bit u1, input bit d1, input bit u2, input bit d2);
    int nx, ny, ndx, ndy;
    case (m_mode)
      0, 3: if (st) begin
        m_s1 = 0; m_s2 = 0; m_bx = 316; m_by = 236; m_dx = 1; m_cnt = 0; m_mode = 1;
      end
      1: begin
        m_p1 = pad(m_p1, u1, d1); m_p2 = pad(m_p2, u2, d2);
        if (m_cnt == 59) begin m_mode = 2; m_cnt = 0; end
        else m_cnt++;
      end
      default: begin
        nx = m_bx + 2 * m_dx; ny = m_by + 2 * m_dy; ndx = m_dx; ndy = m_dy;
        if (ny <= 0) begin ny = 0; ndy = 1; end
        else if (ny >= 472) begin ny = 472; ndy = -1; end
        if (m_dx < 0 && nx <= 24 && nx + 8 > 16 && y_overlap(m_by, m_p1)) begin
          nx = 24; ndx = 1;
        end else if (m_dx > 0 && nx + 8 >= 616 && nx < 624 && y_overlap(m_by, m_p2)) begin
          nx = 608; ndx = -1;
        end else if (nx <= 0) begin
          m_s2++; nx = 316; ny = 236; ndx = -1;
          m_mode = (m_s2 == 9) ? 3 : 1;
        end else if (nx >= 632) begin
          m_s1++; nx = 316; ny = 236; ndx = 1;
          m_mode = (m_s1 == 9) ? 3 : 1;
        end
        m_p1 = pad(m_p1, u1, d1); m_p2 = pad(m_p2, u2, d2);
        m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit st, input bit u1, input bit d1, input bit u2, input bit d2,
                       input int hi);
    vsync = 1'b1; start = st;
    p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
    cyc();
    start = 1'b0;
    repeat (hi - 1) cyc();
    vsync = 1'b0;
    cyc(); cyc();
    model_tick(st, u1, d1, u2, d2);
    check_frame("frame");
  endtask

  task automatic do_reset();
    rst = 1'b1; vsync = 1'b0; start = 1'b0;
    p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
    cyc(); cyc();
    rst = 1'b0;
    model_reset();
    check_frame("reset");
  endtask

  initial begin
    bit u1, d1, u2, d2, st;
    int frames;

    // Ball engine boundary table
    add_vec( 26, 100, 0, 1,  80,   0,  24, 102, 1, 1, 0, 0);
    add_vec( 26, 100, 0, 1, 300,   0,  24, 102, 0, 1, 0, 0);
    add_vec(  2, 100, 0, 1, 300,   0, 316, 236, 0, 1, 1, 0);
    add_vec(606,  50, 1, 0,   0,  20, 608,  48, 0, 0, 0, 0);
    add_vec(630, 300, 1, 1,   0,   0, 316, 236, 1, 1, 0, 1);
    add_vec(100,   2, 1, 0,   0,   0, 102,   0, 1, 1, 0, 0);
    add_vec(100, 470, 0, 1,   0,   0,  98, 472, 0, 0, 0, 0);
    add_vec( 26,   2, 0, 0,   0,   0,  24,   0, 1, 1, 0, 0);
    add_vec( 10, 100, 0, 1,  80,   0,   8, 102, 0, 1, 0, 0);
    add_vec( 26, 100, 0, 1, 108,   0,  24, 102, 0, 1, 0, 0);
    add_vec( 26, 100, 0, 1, 107,   0,  24, 102, 1, 1, 0, 0);
    add_vec( 26, 100, 0, 1,  36,   0,  24, 102, 0, 1, 0, 0);
    add_vec( 26, 100, 0, 1,  37,   0,  24, 102, 1, 1, 0, 0);
    add_vec( 20, 100, 1, 1,  80,   0,  22, 102, 1, 1, 0, 0);
    add_vec(622, 100, 1, 1,   0,  80, 624, 102, 1, 1, 0, 0);
    add_vec( 18, 100, 0, 1,  80,   0,  24, 102, 1, 1, 0, 0);
    add_vec(  2,   2, 0, 0, 300,   0, 316, 236, 0, 1, 1, 0);
    foreach (vecs[i]) begin
      e_bx = 11'(vecs[i].bx); e_by = 11'(vecs[i].by); e_dx = vecs[i].dx[0]; e_dy = vecs[i].dy[0];
      e_p1 = 11'(vecs[i].p1); e_p2 = 11'(vecs[i].p2);
      #1;
      check($sformatf("eng[%0d]", i),
            {e_nx, e_ny, e_ndx, e_ndy, e_ml, e_mr},
            {11'(vecs[i].ex), 11'(vecs[i].ey), vecs[i].edx[0], vecs[i].edy[0],
             vecs[i].eml[0], vecs[i].emr[0]});
    end

    // Idle frames without start
    do_reset();
    repeat (3) frame(0, 0, 0, 0, 0, 1);
    check("idle_state", {mode, p1_score, p2_score, p1_y, p2_y, ball_x, ball_y},
          {2'd0, 6'd0, 6'd0, 11'd208, 11'd208, 11'd316, 11'd236});

    // Serve delay and first play step
    frame(1, 0, 0, 0, 0, 1);
    check("serve_mode", mode, 1);
    repeat (59) frame(0, 0, 0, 0, 0, 1);
    check("serve_59", mode, 1);
    frame(0, 0, 0, 0, 0, 1);
    check("play_mode", mode, 2);
    frame(0, 0, 0, 0, 0, 1);
    check("first_move", {ball_x, ball_y}, {11'd318, 11'd238});
    repeat (5) frame(0, 0, 0, 0, 0, 1);

    // Reset mid-play, then a long vsync pulse must count as one frame
    rst = 1'b1;
    cyc();
    model_reset();
    check_frame("mid_reset");
    rst = 1'b0;
    frame(1, 0, 0, 0, 0, 10);
    repeat (59) frame(0, 0, 0, 0, 0, 1);
    check("long_vsync_serve", mode, 1);
    frame(0, 0, 0, 0, 0, 1);
    check("long_vsync_play", mode, 2);

    // Paddle clamping and both-buttons hold
    do_reset();
    frame(1, 0, 0, 0, 0, 1);
    repeat (50) frame(0, 1, 0, 1, 1, 1);
    frame(0, 1, 0, 1, 1, 1); check("p1_up_4", p1_y, 4);
    frame(0, 1, 0, 1, 1, 1); check("p1_up_0", p1_y, 0);
    frame(0, 1, 0, 1, 1, 1); check("p1_up_floor", p1_y, 0);
    check("p2_both_hold", p2_y, 208);
    repeat (103) frame(0, 0, 1, 0, 0, 1);
    check("p1_down_412", p1_y, 412);
    frame(0, 0, 1, 0, 0, 1); check("p1_down_416", p1_y, 416);
    frame(0, 0, 1, 0, 0, 1); check("p1_down_cap", p1_y, 416);

    // Random play with occasional start requests
    for (int i = 0; i < 1500; i++) begin
      st = ($urandom_range(0, 49) == 0);
      u1 = 1'($urandom); d1 = 1'($urandom); u2 = 1'($urandom); d2 = 1'($urandom);
      frame(st, u1, d1, u2, d2, int'($urandom_range(1, 3)));
    end

    // Paddles dodge the ball until someone wins
    if (m_mode == 0 || m_mode == 3) frame(1, 0, 0, 0, 0, 1);
    frames = 0;
    while (m_mode != 3 && frames < 4000) begin
      u1 = (m_by >= 240);
      frame(0, u1, !u1, u1, !u1, 1);
      frames++;
    end
    check("over_mode", mode, 3);
    check("win_score", (p1_score == 6'd9) || (p2_score == 6'd9), 1);
    for (int i = 0; i < 20; i++) begin
      u1 = 1'($urandom); d1 = 1'($urandom); u2 = 1'($urandom); d2 = 1'($urandom);
      frame(0, u1, d1, u2, d2, 1);
    end
    frame(1, 0, 0, 0, 0, 1);
    check("restart", {mode, p1_score, p2_score}, {2'd1, 6'd0, 6'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
